// File: rtl/pixel_window_sequencer_if.sv
// Bundle of the row-memory read port, the control strobes and the window
// handshake between the sequencer and its neighbours.
interface pixel_window_sequencer_if #(
   parameter int unsigned AW = 5
);
   logic          start;
   logic          busy;
   logic          done;
   logic          row_rd_en;
   logic [AW-1:0] row_rd_addr;
   logic [23:0]   row_rd_data;
   logic [23:0]   line0;
   logic [23:0]   line1;
   logic [23:0]   line2;
   logic [4:0]    sel;
   logic          zero;
   logic          win_valid;
   logic          win_ready;
   logic [AW-1:0] win_row;
   logic          win_last;

   modport master (
      input  start, row_rd_data, win_ready,
      output busy, done, row_rd_en, row_rd_addr, line0, line1, line2, sel, zero,
             win_valid, win_row, win_last
   );

   modport slave (
      output start, row_rd_data, win_ready,
      input  busy, done, row_rd_en, row_rd_addr, line0, line1, line2, sel, zero,
             win_valid, win_row, win_last
   );
endinterface

// File: rtl/pixel_window_sequencer.sv
// 3x3 window scan over a ROWS x 24 one-bit image: preloads three line registers,
// then walks the window centre column by column and row by row.
module pixel_window_sequencer #(
   parameter int unsigned ROWS = 24,
   parameter int unsigned AW   = 5
) (
   input logic                      clk,
   input logic                      rstn,
   pixel_window_sequencer_if.master bus
);
   localparam logic [AW-1:0] LastRow = AW'(ROWS - 1);
   localparam logic [4:0]    LastCol = 5'd23;

   typedef enum logic [2:0] {
      StIdle, StPre0, StPre1, StPre2, StRun, StFetch, StFill, StDone
   } state_e;

   state_e        r_state;
   logic          r_busy;
   logic          r_done;
   logic          r_rd_en;
   logic [AW-1:0] r_rd_addr;
   logic          r_valid;
   logic [AW-1:0] r_row;
   logic [4:0]    r_sel;
   logic [23:0]   r_line0;
   logic [23:0]   r_line1;
   logic [23:0]   r_line2;

   logic w_zero;
   logic w_has_next;

   assign w_zero = (r_row == LastRow);
   // Row r+2 exists, i.e. once the centre moves to r+1 there is a row below it
   assign w_has_next = (32'(r_row) + 32'd2) <= (ROWS - 1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= StIdle;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_valid   <= 1'b0;
         r_row     <= '0;
         r_sel     <= '0;
         r_line0   <= '0;
         r_line1   <= '0;
         r_line2   <= '0;
      end else begin
         r_done    <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         case (r_state)
            StIdle: begin
               if (bus.start) begin
                  r_state <= StPre0;
                  r_busy  <= 1'b1;
                  r_rd_en <= 1'b1;
               end
            end
            StPre0: begin
               r_line0   <= '0;
               r_rd_en   <= 1'b1;
               r_rd_addr <= AW'(1);
               r_state   <= StPre1;
            end
            StPre1: begin
               r_line1 <= bus.row_rd_data;
               r_state <= StPre2;
            end
            StPre2: begin
               r_line2 <= bus.row_rd_data;
               r_row   <= '0;
               r_sel   <= '0;
               r_valid <= 1'b1;
               r_state <= StRun;
            end
            StRun: begin
               if (bus.win_ready) begin
                  if (r_sel != LastCol) begin
                     r_sel <= r_sel + 5'd1;
                  end else if (!w_zero) begin
                     r_sel     <= '0;
                     r_line0   <= r_line1;
                     r_line1   <= r_line2;
                     r_row     <= r_row + AW'(1);
                     r_valid   <= 1'b0;
                     r_rd_en   <= w_has_next;
                     r_rd_addr <= w_has_next ? AW'(32'(r_row) + 32'd2) : '0;
                     r_state   <= StFetch;
                  end else begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= StDone;
                  end
               end
            end
            StFetch: r_state <= StFill;
            StFill: begin
               // No read was issued for the bottom row, so the bus holds garbage
               r_line2 <= w_zero ? '0 : bus.row_rd_data;
               r_valid <= 1'b1;
               r_state <= StRun;
            end
            StDone:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.row_rd_en   = r_rd_en;
   assign bus.row_rd_addr = r_rd_addr;
   assign bus.line0       = r_line0;
   assign bus.line1       = r_line1;
   assign bus.line2       = r_line2;
   assign bus.sel         = r_sel;
   assign bus.zero        = w_zero;
   assign bus.win_valid   = r_valid;
   assign bus.win_row     = r_row;
   assign bus.win_last    = w_zero & (r_sel == LastCol);
endmodule

// File: tb/tb_pixel_window_sequencer.sv
// Scoreboard bench: a 24-row and a 2-row sequencer against small image memories.
module tb_pixel_window_sequencer;
   typedef struct packed {
      logic [4:0]  r;
      logic [4:0]  s;
      logic [23:0] l0;
      logic [23:0] l1;
      logic [23:0] l2;
      logic        z;
      logic        last;
   } win_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   pixel_window_sequencer_if #(.AW(5)) ifa ();
   pixel_window_sequencer_if #(.AW(1)) ifb ();

   pixel_window_sequencer #(.ROWS(24), .AW(5)) u_dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
   pixel_window_sequencer #(.ROWS(2), .AW(1)) u_dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

   int checks = 0;
   int errors = 0;

   logic [23:0] mem_a[24];
   logic [23:0] mem_b[2];
   win_t        q_a[$];
   win_t        q_b[$];
   win_t        obs[576];

   int reads_a, bad_a, done_cnt_a, reads_b, bad_b, done_cnt_b;
   logic       pend_en_a = 1'b0;
   logic       pend_en_b = 1'b0;
   logic [4:0] pend_addr_a = '0;
   logic [0:0] pend_addr_b = '0;

   logic [92:0] outs_a;
   logic [84:0] outs_b;
   assign outs_a = {ifa.busy, ifa.done, ifa.row_rd_en, ifa.row_rd_addr, ifa.line0, ifa.line1,
                    ifa.line2, ifa.sel, ifa.zero, ifa.win_valid, ifa.win_row, ifa.win_last};
   assign outs_b = {ifb.busy, ifb.done, ifb.row_rd_en, ifb.row_rd_addr, ifb.line0, ifb.line1,
                    ifb.line2, ifb.sel, ifb.zero, ifb.win_valid, ifb.win_row, ifb.win_last};

   // Row memories: read strobe seen in cycle N gives data throughout cycle N+1
   always @(negedge clk) begin
      pend_en_a   = ifa.row_rd_en;
      pend_addr_a = ifa.row_rd_addr;
      pend_en_b   = ifb.row_rd_en;
      pend_addr_b = ifb.row_rd_addr;
      if (ifa.row_rd_en) begin
         reads_a++;
         if (ifa.row_rd_addr > 5'd23) bad_a++;
      end else if (ifa.row_rd_addr != 5'd0) bad_a++;
      if (ifb.row_rd_en) reads_b++;
      else if (ifb.row_rd_addr != 1'b0) bad_b++;
      if (ifa.done) done_cnt_a++;
      if (ifb.done) done_cnt_b++;
   end

   always @(posedge clk) begin
      #1;
      ifa.row_rd_data = pend_en_a ? mem_a[pend_addr_a] : 24'($urandom);
      ifb.row_rd_data = pend_en_b ? mem_b[pend_addr_b] : 24'($urandom);
   end

   task automatic push_a();
      win_t w;
      for (int r = 0; r < 24; r++) begin
         for (int s = 0; s < 24; s++) begin
            w.r    = 5'(r);
            w.s    = 5'(s);
            w.l0   = (r == 0) ? 24'h0 : mem_a[r-1];
            w.l1   = mem_a[r];
            w.l2   = (r == 23) ? 24'h0 : mem_a[r+1];
            w.z    = (r == 23);
            w.last = (r == 23) && (s == 23);
            q_a.push_back(w);
         end
      end
   endtask

   task automatic start_a();
      @(negedge clk);
      ifa.start = 1'b1;
   endtask

   task automatic run_a(input bit rnd, input int cyc0, input int pulse_cyc, input int abort_r,
                        input int abort_s, output int done_cyc, output int nx);
      int          cyc;
      bit          prev_stall;
      logic [92:0] snap;
      win_t        cur;
      win_t        exp_w;
      cyc = cyc0; done_cyc = -1; nx = 0; prev_stall = 1'b0; snap = '0;
      while (cyc < 3000 && done_cyc < 0) begin
         @(negedge clk);
         cyc++;
         ifa.start     = (cyc == pulse_cyc);
         ifa.win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         cur = {ifa.win_row, ifa.sel, ifa.line0, ifa.line1, ifa.line2, ifa.zero, ifa.win_last};
         if (prev_stall) begin
            checks++;
            if (outs_a !== snap) begin
               errors++;
               $display("FAIL stall_hold: got %h want %h", outs_a, snap);
            end
         end
         if (ifa.win_valid && int'(ifa.win_row) == abort_r && int'(ifa.sel) == abort_s) return;
         if (ifa.win_valid && ifa.win_ready) begin
            checks++;
            if (q_a.size() == 0) begin
               errors++;
               $display("FAIL win_extra: got %h want none", cur);
            end else begin
               exp_w = q_a.pop_front();
               if (cur !== exp_w) begin
                  errors++;
                  $display("FAIL win_a: got %h want %h", cur, exp_w);
               end
            end
            if (nx < 576) obs[nx] = cur;
            nx++;
         end
         prev_stall = ifa.win_valid && !ifa.win_ready;
         snap = outs_a;
         if (ifa.done) done_cyc = cyc;
      end
      ifa.win_ready = 1'b1;
      ifa.start     = 1'b0;
      if (done_cyc < 0) begin
         checks++; errors++;
         $display("FAIL scan_timeout: got no done want done within 3000 cycles");
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      ifa.start = 1'b0; ifa.win_ready = 1'b1;
      ifb.start = 1'b0; ifb.win_ready = 1'b1;
      #1;
      checks++;
      if (outs_a !== '0 || outs_b !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h/%h want 0", outs_a, outs_b);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (outs_a !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got %h want 0", outs_a);
      end
   endtask

   task automatic test_scan();
      int dc, nx, nlast;
      q_a.delete(); push_a();
      reads_a = 0; bad_a = 0; done_cnt_a = 0;
      start_a();
      run_a(1'b0, 0, -1, -1, -1, dc, nx);
      repeat (2) @(negedge clk);
      checks++;
      if (dc != 626 || nx != 576 || q_a.size() != 0) begin
         errors++;
         $display("FAIL scan_timing: got done %0d xfers %0d left %0d want 626 576 0", dc, nx,
                  q_a.size());
      end
      checks++;
      if (reads_a != 24 || bad_a != 0 || done_cnt_a != 1) begin
         errors++;
         $display("FAIL scan_reads: got reads %0d bad %0d done %0d want 24 0 1", reads_a, bad_a,
                  done_cnt_a);
      end
      checks++;
      if ({obs[125].l0, obs[125].l1, obs[125].l2, obs[125].z} !==
          {24'h000010, 24'h000020, 24'h000040, 1'b0}) begin
         errors++;
         $display("FAIL win_5_5: got %h", obs[125]);
      end
      checks++;
      if (obs[0].l0 !== 24'h0 || obs[0].l1 !== 24'h000001) begin
         errors++;
         $display("FAIL win_0_0: got %h want line0 0 line1 000001", obs[0]);
      end
      checks++;
      if ({obs[559].z, obs[559].l2, obs[559].last} !== {1'b1, 24'h0, 1'b0}) begin
         errors++;
         $display("FAIL win_23_7: got %h want zero 1 line2 0 last 0", obs[559]);
      end
      nlast = 0;
      for (int i = 0; i < 576; i++) if (obs[i].last) nlast++;
      checks++;
      if (nlast != 1 || obs[575].last !== 1'b1) begin
         errors++;
         $display("FAIL win_last: got count %0d final %b want 1 1", nlast, obs[575].last);
      end
   endtask

   task automatic test_random_ready();
      int dc, nx;
      q_a.delete(); push_a();
      done_cnt_a = 0;
      start_a();
      run_a(1'b1, 0, -1, -1, -1, dc, nx);
      repeat (2) @(negedge clk);
      checks++;
      if (nx != 576 || q_a.size() != 0 || dc < 626 || done_cnt_a != 1) begin
         errors++;
         $display("FAIL random_ready: got xfers %0d left %0d done@%0d dones %0d want 576 0 >=626 1",
                  nx, q_a.size(), dc, done_cnt_a);
      end
   endtask

   task automatic test_rows2();
      win_t w, cur, exp_w;
      int   cyc, dc, nx, nzero;
      q_b.delete();
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 24; s++) begin
            w.r = 5'(r); w.s = 5'(s);
            w.l0 = (r == 0) ? 24'h0 : mem_b[0];
            w.l1 = mem_b[r];
            w.l2 = (r == 1) ? 24'h0 : mem_b[1];
            w.z = (r == 1);
            w.last = (r == 1) && (s == 23);
            q_b.push_back(w);
         end
      end
      reads_b = 0; bad_b = 0; done_cnt_b = 0;
      cyc = 0; dc = -1; nx = 0; nzero = 0;
      @(negedge clk);
      ifb.start = 1'b1;
      while (cyc < 500 && dc < 0) begin
         @(negedge clk);
         cyc++;
         ifb.start = 1'b0;
         cur = {4'b0, ifb.win_row, ifb.sel, ifb.line0, ifb.line1, ifb.line2, ifb.zero,
                ifb.win_last};
         if (ifb.win_valid && ifb.win_ready) begin
            checks++;
            if (q_b.size() == 0) begin
               errors++;
               $display("FAIL win_b_extra: got %h want none", cur);
            end else begin
               exp_w = q_b.pop_front();
               if (cur !== exp_w) begin
                  errors++;
                  $display("FAIL win_b: got %h want %h", cur, exp_w);
               end
            end
            if (ifb.zero) nzero++;
            nx++;
         end
         if (ifb.done) dc = cyc;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (dc != 54 || nx != 48 || nzero != 24 || q_b.size() != 0) begin
         errors++;
         $display("FAIL rows2_scan: got done %0d xfers %0d zero %0d want 54 48 24", dc, nx, nzero);
      end
      checks++;
      if (reads_b != 2 || bad_b != 0 || done_cnt_b != 1) begin
         errors++;
         $display("FAIL rows2_reads: got reads %0d bad %0d done %0d want 2 0 1", reads_b, bad_b,
                  done_cnt_b);
      end
   endtask

   task automatic test_reset_mid_scan();
      int dc, nx;
      q_a.delete(); push_a();
      done_cnt_a = 0;
      start_a();
      run_a(1'b0, 0, -1, 10, 3, dc, nx);
      checks++;
      if (dc != -1 || nx != 243) begin
         errors++;
         $display("FAIL abort_point: got done %0d xfers %0d want -1 243", dc, nx);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (outs_a !== '0) begin
         errors++;
         $display("FAIL reset_async: got %h want 0", outs_a);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (outs_a !== '0 || done_cnt_a != 0) begin
         errors++;
         $display("FAIL reset_hold: got %h dones %0d want 0 0", outs_a, done_cnt_a);
      end
      rstn = 1'b1;
      q_a.delete(); push_a();
      reads_a = 0;
      start_a();
      run_a(1'b0, 0, -1, -1, -1, dc, nx);
      repeat (2) @(negedge clk);
      checks++;
      if (dc != 626 || nx != 576 || reads_a != 24 || done_cnt_a != 1) begin
         errors++;
         $display("FAIL restart_scan: got done %0d xfers %0d reads %0d dones %0d want 626 576 24 1",
                  dc, nx, reads_a, done_cnt_a);
      end
   endtask

   task automatic test_start_ignored();
      int dc, nx;
      q_a.delete(); push_a();
      done_cnt_a = 0;
      start_a();
      run_a(1'b0, 0, 100, -1, -1, dc, nx);
      checks++;
      if (dc != 626 || nx != 576) begin
         errors++;
         $display("FAIL start_busy: got done %0d xfers %0d want 626 576", dc, nx);
      end
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      checks++;
      if ({ifa.busy, ifa.row_rd_en, ifa.done, ifa.win_valid} !== 4'b0) begin
         errors++;
         $display("FAIL start_in_done: got %b want 0000",
                  {ifa.busy, ifa.row_rd_en, ifa.done, ifa.win_valid});
      end
      ifa.start = 1'b1;
      push_a();
      @(negedge clk);
      ifa.start = 1'b0;
      checks++;
      if ({ifa.busy, ifa.row_rd_en, ifa.row_rd_addr} !== {1'b1, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL start_after_done: got %b want 1100000",
                  {ifa.busy, ifa.row_rd_en, ifa.row_rd_addr});
      end
      run_a(1'b0, 1, -1, -1, -1, dc, nx);
      repeat (2) @(negedge clk);
      checks++;
      if (dc != 626 || nx != 576 || done_cnt_a != 2) begin
         errors++;
         $display("FAIL second_scan: got done %0d xfers %0d dones %0d want 626 576 2", dc, nx,
                  done_cnt_a);
      end
   endtask

   initial begin
      for (int k = 0; k < 24; k++) mem_a[k] = 24'h000001 << k;
      mem_b[0] = 24'hFFFFFF;
      mem_b[1] = 24'hAAAAAA;
      test_reset();
      test_scan();
      test_random_ready();
      test_rows2();
      test_reset_mid_scan();
      test_start_ignored();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish want finish before 1000000");
      $fatal(1);
   end
endmodule

// File: doc/pixel_window_sequencer.md
Name: pixel_window_sequencer

Overview:
- Sequences a 3x3 binary-pixel window scan over a ROWS x 24 one-bit image held in a row memory.
- Keeps three 24-bit line registers: previous, current and next row. It drives the pixel decoder's line inputs, column select and bottom-row zero flag, and presents each window position downstream with a valid/ready handshake.
- Sits between the image row buffer and the pixel decoder / convolution datapath. It is started by a control register pulse.

Parameters:
ROWS, 24, image height in rows (legal range 2..32)
AW, 5, row address width (ceil(log2(ROWS)), minimum 1)

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle scan request, sampled only in IDLE
busy  out  1  high in every state except IDLE and DONE
done  out  1  single-cycle pulse at end of scan
row_rd_en  out  1  row memory read strobe
row_rd_addr  out  AW  row memory read address
row_rd_data  in  24  row memory data, valid the cycle after row_rd_en
line0  out  24  row r-1 (all zero when r=0)
line1  out  24  row r
line2  out  24  row r+1 (all zero when r=ROWS-1)
sel  out  5  column index 0..23 of the window centre
zero  out  1  high while r=ROWS-1
win_valid  out  1  window (line0..2, sel, zero, win_row) valid
win_ready  in  1  downstream accepts the window
win_row  out  AW  current centre row r
win_last  out  1  high when r=ROWS-1 and sel=23

Behaviour:
- Reset values: all outputs 0; state IDLE; line registers, sel and row counter 0.
- States and transitions:
  - IDLE -> PRE0 on start. start is ignored in all other states.
  - PRE0: row_rd_en=1, addr=0. line0<=0.
  - PRE1: row_rd_en=1, addr=1. line1<=row_rd_data.
  - PRE2: line2<=row_rd_data; r<=0; sel<=0 -> RUN.
  - RUN: win_valid=1.
    - On win_valid&win_ready with sel<23: sel<=sel+1.
    - With sel=23 and r<ROWS-1: sel<=0, line0<=line1, line1<=line2, r<=r+1 -> FETCH.
    - With sel=23 and r=ROWS-1 -> DONE.
  - FETCH: if r+1<=ROWS-1, row_rd_en=1 with addr=r+1 (r already incremented); else no read. -> FILL.
  - FILL: line2<=row_rd_data if a read was issued, else line2<=0. -> RUN.
  - DONE: done=1 for one cycle -> IDLE.
- Handshake rules:
  - While win_valid=1 and win_ready=0, all window outputs hold stable.
  - win_valid never drops without a transfer.
  - win_valid=0 outside RUN.
- Throughput: one window per cycle while win_ready=1. Two bubble cycles (FETCH, FILL) per row change; three preload cycles.
- Timing with win_ready tied high: done is high in cycle 3+26*ROWS-1 after the start-sampling edge, i.e. cycle 626 for ROWS=24. Total handshakes = 24*ROWS.
- zero is combinational from r==ROWS-1 and is valid in every state. line2 is additionally forced to 0 in the last row, so downstream sees zeros either way.
- Memory reads never address beyond ROWS-1. row_rd_addr is 0 whenever row_rd_en=0.
- ROWS=2: the FETCH for r=1 issues no read; the r=1 windows have zero=1.
- Reset asserted mid-scan returns immediately to IDLE with every output at its reset value. No done pulse is produced. The next start performs a full scan.
- A start pulse in the same cycle as the DONE state is ignored. It is accepted only from IDLE on the following cycle.

Test Plan:
- ROWS=24, row k = 24'h000001<<k, win_ready=1, pulse start: 576 windows in order (r,sel) = (0,0)..(23,23).
  - Window (5,5): line0=24'h000010, line1=24'h000020, line2=24'h000040, zero=0.
  - done in cycle 626; exactly 2 reads per preload and 1 per row change for rows 2..23 (24 reads total).
- Same image, window (0,0): line0=0; window (23,7): zero=1, line2=0, win_last only at (23,23).
- win_ready toggled by a random 50% pattern: outputs stable whenever valid&!ready; the sequence of accepted windows is identical to the first scenario; done arrives after all 576 transfers.
- ROWS=2, rows 24'hFFFFFF and 24'hAAAAAA: 48 windows; row 0 line2=24'hAAAAAA; row 1 line0=24'hFFFFFF, zero=1; no read with addr>1.
- rstn low at window (10,3), then released and start pulsed: no done during the aborted scan; all outputs 0 while in reset; the new scan restarts at (0,0) with a complete 576-window sequence.
- start pulsed while busy and in the DONE cycle: ignored (single done, no second scan); a start one cycle after done begins a new PRE0.
